noc_vc_link_buffer: RTL and testbench

- Per-virtual-channel elastic buffer on one NoC link, inserted between a router output port and the neighbouring router or tile input, in either direction.
- Accepts flits from the upstream stage into one FIFO per VC.
- Drives them onto a single shared downstream flit bus, using round-robin arbitration among VCs that have data and are ready.
- Decouples ready timing between routers and absorbs bursts.

---
 rtl/noc_vc_link_buffer.sv | 134 +++++++++++++
 tb/tb_noc_vc_link_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_link_buffer.sv
// Per-VC elastic link buffer: one circular FIFO per VC, round-robin drain onto a shared flit bus.
// Optional packet lock (grant held on one VC until its last flit) under `define NOC_LINK_PKT_LOCK_EN.
module noc_vc_link_buffer #(
    parameter int FLIT_WIDTH   = 32,
    parameter int VCHANNELS    = 2,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [FLIT_WIDTH-1:0] in_flit_i,
    input  logic                  in_last_i,
    input  logic [VCHANNELS-1:0]  in_valid_i,
    output logic [VCHANNELS-1:0]  in_ready_o,
    output logic [FLIT_WIDTH-1:0] out_flit_o,
    output logic                  out_last_o,
    output logic [VCHANNELS-1:0]  out_valid_o,
    input  logic [VCHANNELS-1:0]  out_ready_i
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

    logic [FLIT_WIDTH:0]  mem_q    [VCHANNELS][BUFFER_DEPTH];
    logic [PW-1:0]        wr_ptr_q [VCHANNELS];
    logic [PW-1:0]        rd_ptr_q [VCHANNELS];
    logic [CW-1:0]        cnt_q    [VCHANNELS];
    logic [VW-1:0]        rr_q;

    logic [VCHANNELS-1:0] full, wr_en, rd_en, cand_raw, cand;
    logic [VW-1:0]        wr_vc, gnt_vc;
    logic                 wr_req, gnt;
    logic [FLIT_WIDTH:0]  head;

    function automatic logic [VW-1:0] wrap_vc(input logic [VW-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        s = s % VCHANNELS;
        return VW'(s);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int v = 0; v < VCHANNELS; v++) begin
            full[v]     = (cnt_q[v] == CW'(BUFFER_DEPTH));
            cand_raw[v] = (cnt_q[v] != '0) && out_ready_i[v];
        end
        in_ready_o = ~full;
    end

    // Multi-hot in_valid is a protocol error: only the lowest set VC is considered.
    always_comb begin
        wr_vc  = '0;
        wr_req = |in_valid_i;
        wr_en  = '0;
        for (int v = VCHANNELS - 1; v >= 0; v--) begin
            if (in_valid_i[v]) wr_vc = VW'(v);
        end
        if (wr_req && !full[wr_vc]) wr_en[wr_vc] = 1'b1;
    end

`ifdef NOC_LINK_PKT_LOCK_EN
    logic          lock_q;
    logic [VW-1:0] lock_vc_q;

    always_comb begin
        cand = cand_raw;
        if (lock_q) begin
            cand            = '0;
            cand[lock_vc_q] = cand_raw[lock_vc_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
        end else if (gnt) begin
            lock_q    <= ~head[FLIT_WIDTH];
            lock_vc_q <= gnt_vc;
        end
    end
`else
    always_comb cand = cand_raw;
`endif

    always_comb begin
        gnt    = 1'b0;
        gnt_vc = rr_q;
        rd_en  = '0;
        head   = '0;
        for (int unsigned i = 0; i < VCHANNELS; i++) begin
            if (!gnt && cand[wrap_vc(rr_q, i)]) begin
                gnt    = 1'b1;
                gnt_vc = wrap_vc(rr_q, i);
            end
        end
        if (gnt) begin
            rd_en[gnt_vc] = 1'b1;
            head          = mem_q[gnt_vc][rd_ptr_q[gnt_vc]];
        end
        out_valid_o = rd_en;
        out_flit_o  = head[FLIT_WIDTH-1:0];
        out_last_o  = head[FLIT_WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
            for (int v = 0; v < VCHANNELS; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
        end else begin
            if (gnt) rr_q <= wrap_vc(gnt_vc, 1);
            for (int v = 0; v < VCHANNELS; v++) begin
                if (wr_en[v]) wr_ptr_q[v] <= next_ptr(wr_ptr_q[v]);
                if (rd_en[v]) rd_ptr_q[v] <= next_ptr(rd_ptr_q[v]);
                if (wr_en[v] && !rd_en[v]) cnt_q[v] <= cnt_q[v] + CW'(1);
                else if (!wr_en[v] && rd_en[v]) cnt_q[v] <= cnt_q[v] - CW'(1);
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by the counts.
    always_ff @(posedge clk_i) begin
        if (wr_req && !full[wr_vc]) mem_q[wr_vc][wr_ptr_q[wr_vc]] <= {in_last_i, in_flit_i};
    end

endmodule

// File: tb/tb_noc_vc_link_buffer.sv
// Bench for noc_vc_link_buffer: queue-based reference model checked every cycle,
// directed literal scenarios, then randomized traffic with a mid-run reset.
module tb_noc_vc_link_buffer;

    localparam int DEPTH = 4;
`ifdef NOC_LINK_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_flit = '0;
    logic        in_last = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = '0;

    int tests = 0;
    int failures = 0;

    // Reference model state
    logic [32:0] mq[2][$];
    int          rr = 0;
    bit          locked = 1'b0;
    int          lvc = 0;

    // Last sampled DUT outputs, for literal checks
    logic [1:0]  obs_valid, obs_rdy;
    logic [31:0] obs_flit;

    noc_vc_link_buffer #(.FLIT_WIDTH(32), .VCHANNELS(2), .BUFFER_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_flit_i(in_flit), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_flit_o(out_flit), .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq[0].delete();
        mq[1].delete();
        rr = 0;
        locked = 1'b0;
        lvc = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic [1:0] vld, input logic [31:0] fl, input logic lst,
                        input logic [1:0] ordy);
        int g, wv;
        logic [1:0]  ev, er;
        logic [32:0] eh;
        @(negedge clk);
        in_valid = vld; in_flit = fl; in_last = lst; out_ready = ordy;
        #1;
        g = -1;
        if (LOCK_EN && locked) begin
            if (mq[lvc].size() != 0 && ordy[lvc]) g = lvc;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int v;
                v = (rr + i) % 2;
                if (g < 0 && mq[v].size() != 0 && ordy[v]) g = v;
            end
        end
        ev = (g >= 0) ? (2'b01 << g) : 2'b00;
        eh = (g >= 0) ? mq[g][0] : 33'd0;
        er = {mq[1].size() != DEPTH, mq[0].size() != DEPTH};
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_flit",  64'(out_flit),  64'(eh[31:0]));
        chk("out_last",  64'(out_last),  64'(eh[32]));
        chk("in_ready",  64'(in_ready),  64'(er));
        obs_valid = out_valid; obs_flit = out_flit; obs_rdy = in_ready;

        wv = vld[0] ? 0 : (vld[1] ? 1 : -1);
        if (wv >= 0 && mq[wv].size() >= DEPTH) wv = -1;
        if (g >= 0) begin
            void'(mq[g].pop_front());
            rr = (g + 1) % 2;
            locked = !eh[32];
            lvc = g;
        end
        if (wv >= 0) mq[wv].push_back({lst, fl});
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 2'b00; out_ready = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'h3);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_flit",  64'(out_flit),  64'h0);
        chk("rst_out_last",  64'(out_last),  64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  seq_v [6];
        logic [31:0] seq_f [5];

        do_reset();

        // VC0 fill to capacity, 5th write refused, then in-order drain
        for (int i = 0; i < 4; i++) step(2'b01, 32'hA0 + i, 1'b0, 2'b00);
        step(2'b01, 32'hA4, 1'b0, 2'b00);
        chk("full_in_ready", 64'(obs_rdy), 64'h2);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, '0, 1'b0, 2'b01);
            chk("drain_flit", 64'(obs_flit), 64'hA0 + 64'(i));
            if (i == 0) chk("rdy_at_first_read", 64'(obs_rdy), 64'h2);
            if (i == 1) chk("rdy_after_read", 64'(obs_rdy), 64'h3);
        end
        step(2'b00, '0, 1'b0, 2'b01);
        chk("drained_empty", 64'(obs_valid), 64'h0);

        // Full FIFO with concurrent read: write refused, accepted next cycle
        for (int i = 0; i < 4; i++) step(2'b01, 32'hD0 + i, 1'b0, 2'b00);
        step(2'b01, 32'hE0, 1'b1, 2'b01);
        chk("full_rd_rdy", 64'(obs_rdy), 64'h2);
        chk("full_rd_flit", 64'(obs_flit), 64'hD0);
        step(2'b01, 32'hE0, 1'b1, 2'b00);
        chk("after_rd_rdy", 64'(obs_rdy), 64'h3);
        for (int i = 0; i < 5; i++) step(2'b00, '0, 1'b0, 2'b01);

        // Single-flit latency
        step(2'b01, 32'h55, 1'b1, 2'b11);
        chk("lat_same_cycle", 64'(obs_valid), 64'h0);
        step(2'b00, '0, 1'b0, 2'b11);
        chk("lat_valid", 64'(obs_valid), 64'h1);
        chk("lat_flit", 64'(obs_flit), 64'h55);
        step(2'b00, '0, 1'b0, 2'b11);
        chk("lat_once", 64'(obs_valid), 64'h0);

        // Round-robin alternation from RR pointer 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 32'h10 + i, 1'b1, 2'b00);
            step(2'b10, 32'h20 + i, 1'b1, 2'b00);
        end
        for (int i = 0; i < 6; i++) begin
            step(2'b00, '0, 1'b0, 2'b11);
            seq_v[i] = obs_valid;
        end
        for (int i = 0; i < 6; i++) chk("rr_alt", 64'(seq_v[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
        step(2'b01, 32'h30, 1'b1, 2'b00);
        step(2'b10, 32'h40, 1'b1, 2'b00);
        step(2'b00, '0, 1'b0, 2'b10);
        chk("vc1_only", 64'(obs_valid), 64'h2);
        step(2'b00, '0, 1'b0, 2'b10);
        chk("vc1_only_empty", 64'(obs_valid), 64'h0);

        // Multi-flit packet on VC0 competing with VC1
        do_reset();
        step(2'b01, 32'hB0, 1'b0, 2'b00);
        step(2'b01, 32'hB1, 1'b0, 2'b00);
        step(2'b01, 32'hB2, 1'b1, 2'b00);
        step(2'b10, 32'hC0, 1'b1, 2'b00);
        step(2'b10, 32'hC1, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(2'b00, '0, 1'b0, 2'b11);
            seq_f[i] = obs_flit;
        end
        chk("pkt_seq0", 64'(seq_f[0]), 64'hB0);
        chk("pkt_seq1", 64'(seq_f[1]), LOCK_EN ? 64'hB1 : 64'hC0);
        chk("pkt_seq2", 64'(seq_f[2]), LOCK_EN ? 64'hB2 : 64'hB1);
        chk("pkt_seq3", 64'(seq_f[3]), LOCK_EN ? 64'hC0 : 64'hC1);
        chk("pkt_seq4", 64'(seq_f[4]), LOCK_EN ? 64'hC1 : 64'hB2);

        // Downstream stalls VC0 mid-packet
        do_reset();
        step(2'b01, 32'hB0, 1'b0, 2'b00);
        step(2'b01, 32'hB1, 1'b1, 2'b00);
        step(2'b10, 32'hC0, 1'b1, 2'b00);
        step(2'b00, '0, 1'b0, 2'b11);
        step(2'b00, '0, 1'b0, 2'b10);
        chk("stall_mid_pkt", 64'(obs_valid), LOCK_EN ? 64'h0 : 64'h2);

        // Randomized traffic with a reset in the middle of buffered packets
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] v, r;
            int sel;
            sel = $urandom_range(0, 9);
            v = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            r = 2'($urandom);
            if ($urandom_range(0, 3) == 0) r = 2'b11;
            if (n == 1500) do_reset();
            step(v, $urandom, 1'($urandom_range(0, 2) == 0), r);
        end
        for (int n = 0; n < 12; n++) step(2'b00, '0, 1'b0, 2'b11);
        chk("final_empty_v0", 64'(mq[0].size()), 64'h0);
        chk("final_empty_v1", 64'(mq[1].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
